// File: rtl/branch_commit_queue_pkg.sv
// rtl/branch_commit_queue_pkg.sv - shared constants and truth macros for the branch commit queue
`ifndef BCQ_DEFS_SVH
`define BCQ_DEFS_SVH
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package branch_commit_queue_pkg;
  localparam int BCQ_DEPTH = 16;
  localparam int BCQ_IDX_W = 4;
  localparam int BCQ_TAG_W = 8;
  localparam int BCQ_PC_W  = 32;
endpackage

// File: rtl/branch_commit_queue_storage.sv
// rtl/branch_commit_queue_storage.sv - entry arrays with push/resolve/pop write ports and bulk clear
module branch_commit_queue_storage
  import branch_commit_queue_pkg::*;
#(
  parameter int DEPTH = BCQ_DEPTH,
  parameter int IDX_W = BCQ_IDX_W,
  parameter int TAG_W = BCQ_TAG_W,
  parameter int PC_W  = BCQ_PC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_all,
  input  logic             push_en,
  input  logic [IDX_W-1:0] push_idx,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             push_pred,
  input  logic             res_en,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_jump,
  input  logic [PC_W-1:0]  res_pc,
  input  logic             pop_en,
  input  logic [IDX_W-1:0] head_idx,
  output logic             head_ready,
  output logic [TAG_W-1:0] head_tag,
  output logic             head_pred,
  output logic             head_jump,
  output logic [PC_W-1:0]  head_pc
);

  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic             pred_mem [DEPTH];
  logic             jump_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic             res_hit;

  // Resolutions aimed at empty or squashed slots are silently dropped.
  assign res_hit = res_en && valid_q[res_idx];

  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      if (res_hit) resolved_q[res_idx] <= `TRUE;
      if (push_en) begin
        valid_q[push_idx]    <= `TRUE;
        resolved_q[push_idx] <= `FALSE;
      end
      if (pop_en) begin
        valid_q[head_idx]    <= `FALSE;
        resolved_q[head_idx] <= `FALSE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      tag_mem[push_idx]  <= push_tag;
      pred_mem[push_idx] <= push_pred;
    end
    if (res_hit) begin
      jump_mem[res_idx] <= res_jump;
      pc_mem[res_idx]   <= res_pc;
    end
  end

  assign head_ready = valid_q[head_idx] && resolved_q[head_idx];
  assign head_tag   = tag_mem[head_idx];
  assign head_pred  = pred_mem[head_idx];
  assign head_jump  = jump_mem[head_idx];
  assign head_pc    = pc_mem[head_idx];

endmodule

// File: rtl/branch_commit_queue.sv
// rtl/branch_commit_queue.sv - in-order branch commit queue driving predictor updates and mispredict flush
// Optional statistics counters are enabled with BCQ_STATS_EN.
module branch_commit_queue
  import branch_commit_queue_pkg::*;
#(
  parameter int DEPTH = BCQ_DEPTH,
  parameter int IDX_W = BCQ_IDX_W,
  parameter int TAG_W = BCQ_TAG_W,
  parameter int PC_W  = BCQ_PC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_fetcher_valid,
  input  logic [TAG_W-1:0] in_fetcher_tag,
  input  logic             in_fetcher_pred,
  output logic             out_fetcher_full,
  output logic [IDX_W-1:0] out_fetcher_idx,
  input  logic             in_alu_valid,
  input  logic [IDX_W-1:0] in_alu_idx,
  input  logic             in_alu_jump_res,
  input  logic [PC_W-1:0]  in_alu_pc,
  output logic             out_bp_valid,
  output logic [TAG_W-1:0] out_bp_tag,
  output logic             out_bp_jump_res,
  output logic             out_flush,
  output logic [PC_W-1:0]  out_flush_pc,
  output logic [31:0]      out_stat_commits,
  output logic [31:0]      out_stat_mispred
);

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count, count_nxt;
  logic             bp_valid_q, flush_q, bp_jump_q;
  logic [TAG_W-1:0] bp_tag_q;
  logic [PC_W-1:0]  flush_pc_q;

  logic             head_ready, head_pred, head_jump;
  logic [TAG_W-1:0] head_tag;
  logic [PC_W-1:0]  head_pc;

  logic full, commit, mispredict, flushing, push_ok, res_ok, pop_ok;

  assign full       = (count == (IDX_W+1)'(DEPTH));
  assign commit     = rdy && (count != '0) && head_ready;
  assign mispredict = commit && (head_jump != head_pred);
  // Fetch/ALU traffic is dropped both in the squashing cycle and while the flush pulse is visible.
  assign flushing   = flush_q || mispredict;
  assign push_ok    = rdy && in_fetcher_valid && !full && !flushing;
  assign res_ok     = rdy && in_alu_valid && !flushing;
  assign pop_ok     = commit && !mispredict;

  branch_commit_queue_storage #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)
  ) u_storage (
    .clk        (clk),
    .rst        (rst),
    .clear_all  (mispredict),
    .push_en    (push_ok),
    .push_idx   (tail),
    .push_tag   (in_fetcher_tag),
    .push_pred  (in_fetcher_pred),
    .res_en     (res_ok),
    .res_idx    (in_alu_idx),
    .res_jump   (in_alu_jump_res),
    .res_pc     (in_alu_pc),
    .pop_en     (pop_ok),
    .head_idx   (head),
    .head_ready (head_ready),
    .head_tag   (head_tag),
    .head_pred  (head_pred),
    .head_jump  (head_jump),
    .head_pc    (head_pc)
  );

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + (IDX_W+1)'(1);
      2'b01:   count_nxt = count - (IDX_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      bp_valid_q <= `FALSE;
      flush_q    <= `FALSE;
      bp_tag_q   <= '0;
      bp_jump_q  <= `FALSE;
      flush_pc_q <= '0;
    end else if (rdy) begin
      bp_valid_q <= commit;
      flush_q    <= mispredict;
      if (commit) begin
        bp_tag_q  <= head_tag;
        bp_jump_q <= head_jump;
      end
      if (mispredict) begin
        flush_pc_q <= head_pc;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
      end else begin
        if (push_ok) tail <= tail + IDX_W'(1);
        if (pop_ok)  head <= head + IDX_W'(1);
        count <= count_nxt;
      end
    end else begin
      bp_valid_q <= `FALSE;
      flush_q    <= `FALSE;
    end
  end

  assign out_fetcher_full = full;
  assign out_fetcher_idx  = tail;
  assign out_bp_valid     = bp_valid_q;
  assign out_bp_tag       = bp_tag_q;
  assign out_bp_jump_res  = bp_jump_q;
  assign out_flush        = flush_q;
  assign out_flush_pc     = flush_pc_q;

`ifdef BCQ_STATS_EN
  logic [31:0] stat_commits_q, stat_mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (commit)     stat_commits_q <= stat_commits_q + 32'd1;
      if (mispredict) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign out_stat_commits = stat_commits_q;
  assign out_stat_mispred = stat_mispred_q;
`else
  assign out_stat_commits = '0;
  assign out_stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_commit_queue.sv
// tb/tb_branch_commit_queue.sv - scoreboard bench for branch_commit_queue
module tb_branch_commit_queue;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_fetcher_valid, in_fetcher_pred;
  logic [7:0]  in_fetcher_tag;
  logic        out_fetcher_full;
  logic [3:0]  out_fetcher_idx;
  logic        in_alu_valid, in_alu_jump_res;
  logic [3:0]  in_alu_idx;
  logic [31:0] in_alu_pc;
  logic        out_bp_valid, out_bp_jump_res, out_flush;
  logic [7:0]  out_bp_tag;
  logic [31:0] out_flush_pc, out_stat_commits, out_stat_mispred;

  branch_commit_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetcher_valid(in_fetcher_valid), .in_fetcher_tag(in_fetcher_tag),
    .in_fetcher_pred(in_fetcher_pred), .out_fetcher_full(out_fetcher_full),
    .out_fetcher_idx(out_fetcher_idx), .in_alu_valid(in_alu_valid),
    .in_alu_idx(in_alu_idx), .in_alu_jump_res(in_alu_jump_res), .in_alu_pc(in_alu_pc),
    .out_bp_valid(out_bp_valid), .out_bp_tag(out_bp_tag), .out_bp_jump_res(out_bp_jump_res),
    .out_flush(out_flush), .out_flush_pc(out_flush_pc),
    .out_stat_commits(out_stat_commits), .out_stat_mispred(out_stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic        jr;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t        sb[$];
  int          pulse_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] fpc_model = 32'h0;
  int          t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_commit(input logic [7:0] tag, input logic jr, input logic fl, input logic [31:0] pc);
    exp_t e;
    if (fl) fpc_model = pc;
    e.tag = tag; e.jr = jr; e.fl = fl; e.fpc = fpc_model;
    sb.push_back(e);
  endtask

  task automatic push(input logic [7:0] tag, input logic pred, input logic [3:0] exp_idx);
    in_fetcher_valid = 1'b1;
    in_fetcher_tag   = tag;
    in_fetcher_pred  = pred;
    chk("grant_idx", 32'(out_fetcher_idx), 32'(exp_idx));
    step();
    in_fetcher_valid = 1'b0;
  endtask

  task automatic resolve(input logic [3:0] idx, input logic jr, input logic [31:0] pc);
    in_alu_valid    = 1'b1;
    in_alu_idx      = idx;
    in_alu_jump_res = jr;
    in_alu_pc       = pc;
    step();
    in_alu_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    step(2);
  endtask

  // Monitor: every update pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_bp_valid) begin
        pulse_log.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got tag %0h flush %0b, expected no update", out_bp_tag, out_flush);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bp_tag", 32'(out_bp_tag), 32'(e.tag));
          chk("bp_jump_res", 32'(out_bp_jump_res), 32'(e.jr));
          chk("flush", 32'(out_flush), 32'(e.fl));
          chk("flush_pc", out_flush_pc, e.fpc);
        end
      end else if (out_flush) begin
        checks++;
        errors++;
        $display("FAIL lone_flush: got flush=1 without update, expected flush=0");
      end
    end
  end

  initial begin
    logic [31:0] exp_c, exp_m;
    rst = 1'b1; rdy = 1'b1;
    in_fetcher_valid = 1'b0; in_fetcher_tag = '0; in_fetcher_pred = 1'b0;
    in_alu_valid = 1'b0; in_alu_idx = '0; in_alu_jump_res = 1'b0; in_alu_pc = '0;
    step(3);
    rst = 1'b0;

    chk("rst_full", 32'(out_fetcher_full), 32'd0);
    chk("rst_idx", 32'(out_fetcher_idx), 32'd0);
    chk("rst_bp_valid", 32'(out_bp_valid), 32'd0);
    chk("rst_flush", 32'(out_flush), 32'd0);
    chk("rst_flush_pc", out_flush_pc, 32'd0);
    chk("rst_stat_commits", out_stat_commits, 32'd0);

    // 1: correct prediction, commit two cycles after the resolve is presented
    push(8'h12, 1'b1, 4'd0);
    expect_commit(8'h12, 1'b1, 1'b0, 32'h0);
    pulse_log.delete();
    t0 = cyc;
    resolve(4'd0, 1'b1, 32'h100);
    drain();
    chk("s1_latency", 32'(pulse_log[0] - t0), 32'd2);

    // 2: mispredict flush squashes the queue
    push(8'h05, 1'b1, 4'd1);
    expect_commit(8'h05, 1'b0, 1'b1, 32'h204);
    resolve(4'd1, 1'b0, 32'h204);
    drain();
    chk("s2_full", 32'(out_fetcher_full), 32'd0);
    chk("s2_idx", 32'(out_fetcher_idx), 32'd0);
`ifdef BCQ_STATS_EN
    exp_c = 32'd2; exp_m = 32'd1;
`else
    exp_c = 32'd0; exp_m = 32'd0;
`endif
    chk("s2_stat_commits", out_stat_commits, exp_c);
    chk("s2_stat_mispred", out_stat_mispred, exp_m);

    // 3: fill, overflow push dropped, single commit frees slot 0 for the wrapped tail
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1, 4'(i));
    chk("s3_full", 32'(out_fetcher_full), 32'd1);
    push(8'hEE, 1'b0, 4'd0);
    chk("s3_full_after_drop", 32'(out_fetcher_full), 32'd1);
    chk("s3_idx_after_drop", 32'(out_fetcher_idx), 32'd0);
    expect_commit(8'h20, 1'b1, 1'b0, 32'h0);
    resolve(4'd0, 1'b1, 32'h1000);
    drain();
    chk("s3_not_full", 32'(out_fetcher_full), 32'd0);
    push(8'h40, 1'b1, 4'd0);
    chk("s3_full_again", 32'(out_fetcher_full), 32'd1);
    for (int i = 1; i < 16; i++) expect_commit(8'h20 + 8'(i), 1'b1, 1'b0, 32'h0);
    expect_commit(8'h40, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i < 16; i++) resolve(4'(i), 1'b1, 32'h2000 + 32'(i));
    resolve(4'd0, 1'b1, 32'h3000);
    drain();

    // 4: out-of-order resolve, in-order back-to-back commits (head now 1)
    push(8'h0A, 1'b0, 4'd1);
    push(8'h0B, 1'b1, 4'd2);
    expect_commit(8'h0A, 1'b0, 1'b0, 32'h0);
    expect_commit(8'h0B, 1'b1, 1'b0, 32'h0);
    pulse_log.delete();
    resolve(4'd2, 1'b1, 32'h400);
    step(3);
    chk("s4_no_early_commit", 32'(pulse_log.size()), 32'd0);
    resolve(4'd1, 1'b0, 32'h404);
    drain();
    chk("s4_pulses", 32'(pulse_log.size()), 32'd2);
    chk("s4_back_to_back", 32'(pulse_log[1] - pulse_log[0]), 32'd1);

    // 5: mispredict at head with three younger resolved entries
    push(8'h50, 1'b1, 4'd3);
    push(8'h51, 1'b1, 4'd4);
    push(8'h52, 1'b0, 4'd5);
    push(8'h53, 1'b1, 4'd6);
    resolve(4'd4, 1'b1, 32'h510);
    resolve(4'd5, 1'b0, 32'h520);
    resolve(4'd6, 1'b1, 32'h530);
    expect_commit(8'h50, 1'b0, 1'b1, 32'h300);
    resolve(4'd3, 1'b0, 32'h300);
    drain();
    resolve(4'd2, 1'b1, 32'h777);
    resolve(4'd0, 1'b1, 32'h778);
    step(5);
    chk("s5_idx", 32'(out_fetcher_idx), 32'd0);
    chk("s5_full", 32'(out_fetcher_full), 32'd0);
    push(8'h60, 1'b1, 4'd0);
    step(4);
    expect_commit(8'h60, 1'b1, 1'b0, 32'h0);
    resolve(4'd0, 1'b1, 32'h600);
    drain();

    // 6: rdy low freezes a resolved head; commit follows rdy high by one cycle
    push(8'h70, 1'b0, 4'd1);
    resolve(4'd1, 1'b0, 32'h700);
    rdy = 1'b0;
    step(5);
    pulse_log.delete();
    rdy = 1'b1;
    t0 = cyc;
    expect_commit(8'h70, 1'b0, 1'b0, 32'h0);
    drain();
    chk("s6_pulses", 32'(pulse_log.size()), 32'd1);
    chk("s6_latency", 32'(pulse_log[0] - t0), 32'd1);
    chk("s6_flush_pc_held", out_flush_pc, 32'h300);

`ifdef BCQ_STATS_EN
    exp_c = 32'd24; exp_m = 32'd2;
`else
    exp_c = 32'd0; exp_m = 32'd0;
`endif
    chk("end_stat_commits", out_stat_commits, exp_c);
    chk("end_stat_mispred", out_stat_mispred, exp_m);

    // reset in the cycle a commit would fire: no update pulse may escape
    push(8'h80, 1'b1, 4'd2);
    resolve(4'd2, 1'b1, 32'h800);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);
    chk("rst_mid_idx", 32'(out_fetcher_idx), 32'd0);
    chk("rst_mid_full", 32'(out_fetcher_full), 32'd0);
    chk("rst_mid_flush_pc", out_flush_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
